accum_mem_ctrl: RTL and testbench
=================================

ACCUM_MEM_CTRL -- requirements
Module: accum_mem_ctrl

Interface
REQ-001 SHALL have parameter SYS_COL, default 16, number of systolic array columns and accumulator banks.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, partial-sum and accumulator word width.
REQ-003 SHALL have parameter ACCUM_SIZE, default 4096, total accumulator words; ACCUM_ROW = ACCUM_SIZE/SYS_COL (256).
REQ-004 SHALL have parameter SA_LAT, default 16, minimum 1, cycles from start to first column-0 partial sum.
REQ-005 SHALL have ports: clk input 1 clock; rstn input 1 synchronous active-low reset.
REQ-006 SHALL have ports: start input 1 pulse launching a drain; accum_mode input 1 (1 = add into accumulator, 0 = overwrite); num_row input DATA_WIDTH rows to drain.
REQ-007 SHALL have ports: psum_in input SYS_COL x DATA_WIDTH skewed array outputs; rd_data input SYS_COL x DATA_WIDTH accumulator read data, one-cycle read latency.
REQ-008 SHALL have ports: rd_en output SYS_COL; rd_addr output SYS_COL x 8; wr_en output SYS_COL; wr_addr output SYS_COL x 8; wr_data output SYS_COL x DATA_WIDTH.
REQ-009 SHALL have ports: busy output 1 (high outside IDLE); done output 1 single-cycle completion pulse.

Function
REQ-010 SHALL implement FSM IDLE -> WAIT -> RUN -> DRAIN -> IDLE.
REQ-011 In IDLE, start high SHALL latch accum_mode and N = min(num_row, ACCUM_ROW) and enter WAIT; start outside IDLE SHALL be ignored.
REQ-012 N == 0 SHALL return to IDLE, pulse done the cycle after start, and assert no rd_en/wr_en.
REQ-013 WAIT SHALL last SA_LAT cycles, then RUN; with start in cycle 0, arrival strobe arr[0] is first high in cycle SA_LAT+1.
REQ-014 In RUN, arr SHALL shift as {arr[SYS_COL-2:0], inject}, inject high for the first N RUN cycles; arr[c] high in cycles SA_LAT+1+c+r for row r = 0..N-1.
REQ-015 rd_en[c] SHALL equal arr[c] AND latched accum_mode; rd_addr[c] SHALL equal r during row r's strobe.
REQ-016 psum_in[c] SHALL be captured in the arr[c] cycle; the next cycle wr_en[c] = 1, wr_addr[c] = r, and wr_data[c] = rd_data[c] + captured psum (accum_mode = 1) or captured psum (accum_mode = 0).
REQ-017 Addition SHALL wrap modulo 2^DATA_WIDTH; no saturation.
REQ-018 Per-column row counters SHALL increment after each strobe and clear to 0 on leaving RUN; addresses never exceed ACCUM_ROW-1.
REQ-019 RUN SHALL last N+SYS_COL-1 cycles; DRAIN SHALL last 1 cycle, issuing the final column's write.
REQ-020 done SHALL pulse in the cycle after the last wr_en, i.e. cycle SA_LAT+SYS_COL+N+1, together with the return to IDLE.
REQ-021 rd_en and wr_en SHALL be 0 in IDLE and WAIT; wr_data SHALL hold its last value when wr_en is 0.

Reset
REQ-022 rstn low at a clock edge SHALL force IDLE and clear rd_en, wr_en, rd_addr, wr_addr, wr_data, arr, row counters, busy, and done to 0, including mid-RUN.
REQ-023 After rstn rises, no residual enables SHALL appear; the next start SHALL behave as from power-up.

Structure
REQ-024 SYS_COL, DATA_WIDTH, ACCUM_SIZE, ACCUM_ROW, ADDR_WIDTH (8), and the FSM state enum SHALL live in shared package npu_pkg.
REQ-025 Per-column capture, add, and address counter SHALL be sub-module accum_col_lane, instantiated SYS_COL times by generate.

Verification
REQ-026 SA_LAT=16, N=4, accum_mode=0, psum=c*16+r -> arr[0] first at cycle 17; bank c holds c*16+r at addr r; last wr_en (col 15, row 3) at cycle 36; done at cycle 37.
REQ-027 accum_mode=1, banks preloaded with 100, psum=5 -> every written word = 105; rd_en leads wr_en by exactly 1 cycle per column.
REQ-028 Overflow: rd_data=16'hFFFF, psum=2, accum_mode=1 -> wr_data=16'h0001.
REQ-029 num_row=0 -> done at cycle 1, no enables; num_row=300 -> clamped to 256 rows, max address 255, done at SA_LAT+SYS_COL+257.
REQ-030 rstn low at cycle 25 mid-RUN -> all outputs 0 next edge, busy 0; a second start mid-run (without reset) -> ignored, timing unchanged.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU constants and the accumulator-controller state encoding.
// Sized for the default 16-column array with 4096 accumulator words.
package npu_pkg;

    localparam int SYS_COL    = 16;
    localparam int DATA_WIDTH = 16;
    localparam int ACCUM_SIZE = 4096;
    localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL;
    localparam int ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/accum_col_lane.sv
// One accumulator column: captures the column's partial sum on its arrival
// strobe and writes it (optionally added to the bank read data) one cycle later.
module accum_col_lane
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_strobe,
    input  logic                  i_mode,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_psum,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data
);

    logic [ADDR_WIDTH-1:0] r_row;
    logic [DATA_WIDTH-1:0] r_psum;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_hold;
    logic [DATA_WIDTH-1:0] w_sum;

    // Read data for the strobed row lands exactly in the write cycle.
    assign w_sum = i_mode ? (i_rd_data + r_psum) : r_psum;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_row     <= '0;
            r_psum    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_hold <= '0;
        end else begin
            r_wr_en <= i_strobe;
            if (i_strobe) begin
                r_psum    <= i_psum;
                r_wr_addr <= r_row;
            end
            if (i_clr) begin
                r_row <= '0;
            end else if (i_strobe) begin
                r_row <= r_row + ADDR_WIDTH'(1);
            end
            if (r_wr_en) begin
                r_wr_hold <= w_sum;
            end
        end
    end

    assign o_rd_en   = i_strobe & i_mode;
    assign o_rd_addr = r_row;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_en ? w_sum : r_wr_hold;

endmodule

// File: rtl/accum_mem_ctrl.sv
// Drains skewed systolic-array partial sums into per-column accumulator banks,
// either overwriting or read-modify-writing each row.
module accum_mem_ctrl
    import npu_pkg::*;
#(
    parameter int SYS_COL    = npu_pkg::SYS_COL,
    parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
    parameter int ACCUM_SIZE = npu_pkg::ACCUM_SIZE,
    parameter int SA_LAT     = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic                                 accum_mode,
    input  logic [DATA_WIDTH-1:0]                num_row,
    input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]   psum_in,
    input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]   rd_data,
    output logic [SYS_COL-1:0]                   rd_en,
    output logic [SYS_COL-1:0][ADDR_WIDTH-1:0]   rd_addr,
    output logic [SYS_COL-1:0]                   wr_en,
    output logic [SYS_COL-1:0][ADDR_WIDTH-1:0]   wr_addr,
    output logic [SYS_COL-1:0][DATA_WIDTH-1:0]   wr_data,
    output logic                                 busy,
    output logic                                 done,
    output state_t                               dbg_state
);

    localparam int N_ROWS = ACCUM_SIZE / SYS_COL;
    localparam int N_W    = $clog2(N_ROWS + 1);
    localparam int CNT_W  = $clog2(N_ROWS + SYS_COL + SA_LAT) + 1;

    state_t             r_state;
    logic               r_mode;
    logic [N_W-1:0]     r_n;
    logic [N_W-1:0]     r_inj;
    logic [CNT_W-1:0]   r_cnt;
    logic [SYS_COL-1:0] r_arr;
    logic               r_done;

    logic [N_W-1:0]     w_n;
    logic               w_wait_last;
    logic               w_run_last;
    logic               w_inject;

    always_comb begin
        w_n = N_W'(num_row);
        if (num_row > DATA_WIDTH'(N_ROWS)) begin
            w_n = N_W'(N_ROWS);
        end
    end

    assign w_wait_last = (r_state == ST_WAIT) && (r_cnt == CNT_W'(SA_LAT - 1));
    assign w_run_last  = (r_state == ST_RUN)
                       && (r_cnt == CNT_W'(r_n) + CNT_W'(SYS_COL - 2));
    // Row 0 enters on the WAIT->RUN edge; the remaining rows follow one per RUN cycle.
    assign w_inject    = w_wait_last || ((r_state == ST_RUN) && (r_inj < r_n));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_n     <= '0;
            r_inj   <= '0;
            r_cnt   <= '0;
            r_arr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= accum_mode;
                        r_n    <= w_n;
                        r_cnt  <= '0;
                        r_inj  <= '0;
                        if (w_n == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_wait_last) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_run_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_inject) begin
                r_inj <= r_inj + N_W'(1);
            end
            if (w_run_last) begin
                r_arr <= '0;
            end else if (w_inject || (r_state == ST_RUN)) begin
                r_arr <= {r_arr[SYS_COL-2:0], w_inject};
            end
        end
    end

    for (genvar c = 0; c < SYS_COL; c++) begin : g_lane
        accum_col_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .i_strobe  (r_arr[c]),
            .i_mode    (r_mode),
            .i_clr     (w_run_last),
            .i_psum    (psum_in[c]),
            .i_rd_data (rd_data[c]),
            .o_rd_en   (rd_en[c]),
            .o_rd_addr (rd_addr[c]),
            .o_wr_en   (wr_en[c]),
            .o_wr_addr (wr_addr[c]),
            .o_wr_data (wr_data[c])
        );
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_accum_mem_ctrl.sv
// Directed bench for accum_mem_ctrl: a bank-memory environment plus a
// cycle-indexed model of when each column must read, write and finish.
module tb_accum_mem_ctrl;
    import npu_pkg::*;

    localparam int SC     = 16;
    localparam int DW     = 16;
    localparam int SA_LAT = 16;
    localparam int NR     = 256;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   start = 1'b0;
    logic                   accum_mode = 1'b0;
    logic [DW-1:0]          num_row = '0;
    logic [SC-1:0][DW-1:0]  psum_in = '0;
    logic [SC-1:0][DW-1:0]  rd_data = '0;
    logic [SC-1:0]          rd_en;
    logic [SC-1:0][7:0]     rd_addr;
    logic [SC-1:0]          wr_en;
    logic [SC-1:0][7:0]     wr_addr;
    logic [SC-1:0][DW-1:0]  wr_data;
    logic                   busy;
    logic                   done;
    state_t                 dbg_state;

    accum_mem_ctrl #(
        .SYS_COL    (SC),
        .DATA_WIDTH (DW),
        .ACCUM_SIZE (4096),
        .SA_LAT     (SA_LAT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .accum_mode (accum_mode),
        .num_row    (num_row),
        .psum_in    (psum_in),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] mem  [SC][NR];
    logic [DW-1:0] snap [SC][NR];
    logic [DW-1:0] last_wd [SC];
    logic          pend_en [SC];
    logic [7:0]    pend_a  [SC];

    bit  have_run = 1'b0;
    bit  rst_prev = 1'b0;
    bit  m_mode = 1'b0;
    int  k = 0;
    int  m_n = 0;
    int  pat = 0;
    int  first_wr0, last_wr15, first_rd0, done_k, max_wa;
    bit  rd_seen;

    function automatic int row_at(input int c, input int off);
        return k - SA_LAT - off - c;
    endfunction

    function automatic bit row_ok(input int r);
        return have_run && (r >= 0) && (r < m_n);
    endfunction

    function automatic logic [DW-1:0] pval(input int c, input int r);
        case (pat)
            0:       return DW'(c * 16 + r);
            1:       return DW'(5);
            default: return DW'(2);
        endcase
    endfunction

    function automatic bit m_busy();
        return have_run && (m_n > 0) && (k >= 1) && (k <= SA_LAT + SC + m_n);
    endfunction

    function automatic bit m_done();
        if (!have_run) return 1'b0;
        if (m_n == 0) return k == 1;
        return k == SA_LAT + SC + m_n + 1;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s col=%0d k=%0d actual=%0h required=%0h", nm, c, k, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic [SC-1:0] e_rd;
        logic [SC-1:0] e_wr;
        logic [DW-1:0] ev;
        int r;
        chk("busy", -1, 32'(busy), 32'(m_busy()));
        chk("done", -1, 32'(done), 32'(m_done()));
        chk("idle_state", -1, 32'(dbg_state == ST_IDLE), 32'(!m_busy()));
        for (int c = 0; c < SC; c++) begin
            e_rd[c] = m_mode && row_ok(row_at(c, 1));
            e_wr[c] = row_ok(row_at(c, 2));
        end
        chk("rd_en", -1, 32'(rd_en), 32'(e_rd));
        chk("wr_en", -1, 32'(wr_en), 32'(e_wr));
        for (int c = 0; c < SC; c++) begin
            r = row_at(c, 1);
            if (e_rd[c]) chk("rd_addr", c, 32'(rd_addr[c]), 32'(r));
            if (!have_run) begin
                chk("rd_addr_idle", c, 32'(rd_addr[c]), 32'(0));
                chk("wr_addr_idle", c, 32'(wr_addr[c]), 32'(0));
            end
            r = row_at(c, 2);
            if (e_wr[c]) begin
                ev = m_mode ? DW'(snap[c][r] + pval(c, r)) : pval(c, r);
                chk("wr_addr", c, 32'(wr_addr[c]), 32'(r));
                chk("wr_data", c, 32'(wr_data[c]), 32'(ev));
                last_wd[c] = ev;
            end else begin
                chk("wr_hold", c, 32'(wr_data[c]), 32'(last_wd[c]));
            end
        end
    endtask

    task automatic step(input bit st, input int nrow, input bit md, input bit rv);
        int r;
        @(posedge clk);
        #1;
        if (have_run) k++;
        if (!rst_prev) begin
            have_run = 1'b0;
            k = 0;
            for (int c = 0; c < SC; c++) begin
                last_wd[c] = '0;
                pend_en[c] = 1'b0;
            end
        end
        rstn = rv;
        rst_prev = rv;
        start = st;
        num_row = DW'(nrow);
        accum_mode = md;
        if (st && rv && !m_busy()) begin
            have_run = 1'b1;
            k = 0;
            m_n = (nrow > NR) ? NR : nrow;
            m_mode = md;
            snap = mem;
        end
        for (int c = 0; c < SC; c++) begin
            r = row_at(c, 1);
            psum_in[c] = row_ok(r) ? pval(c, r) : DW'($urandom);
            rd_data[c] = (pend_en[c] === 1'b1) ? mem[c][pend_a[c]] : DW'($urandom);
        end
        @(negedge clk);
        check_cycle();
        for (int c = 0; c < SC; c++) begin
            pend_en[c] = rd_en[c];
            pend_a[c]  = rd_addr[c];
            if (wr_en[c] === 1'b1) begin
                mem[c][wr_addr[c]] = wr_data[c];
                if (have_run && int'(wr_addr[c]) > max_wa) max_wa = int'(wr_addr[c]);
            end
        end
        if (have_run) begin
            if (done === 1'b1 && done_k < 0) done_k = k;
            if (rd_en[0] === 1'b1 && first_rd0 < 0) first_rd0 = k;
            if (wr_en[0] === 1'b1 && first_wr0 < 0) first_wr0 = k;
            if (wr_en[SC-1] === 1'b1) last_wr15 = k;
            if (|rd_en) rd_seen = 1'b1;
        end
    endtask

    task automatic preload(input logic [DW-1:0] v);
        foreach (mem[c, a]) mem[c][a] = v;
    endtask

    task automatic run_case(input int nrow, input bit md, input int p, input int ncyc,
                            input int xstart_k, input int rst_k);
        pat = p;
        first_wr0 = -1;
        last_wr15 = -1;
        first_rd0 = -1;
        done_k = -1;
        max_wa = -1;
        rd_seen = 1'b0;
        step(1'b1, nrow, md, 1'b1);
        for (int i = 1; i < ncyc; i++) begin
            step(i == xstart_k, 10, !md, i != rst_k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d actual=timeout required=finish", k);
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < SC; c++) begin
            last_wd[c] = '0;
            pend_en[c] = 1'b0;
            pend_a[c]  = '0;
        end
        preload('0);
        repeat (3) step(1'b0, 0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0, 1'b1);

        // overwrite drain, c*16+r pattern
        preload(16'hAAAA);
        run_case(4, 1'b0, 0, 42, -1, -1);
        chk("ow_first_wr0", -1, 32'(first_wr0), 32'(18));
        chk("ow_last_wr15", -1, 32'(last_wr15), 32'(36));
        chk("ow_done", -1, 32'(done_k), 32'(37));
        chk("ow_no_rd", -1, 32'(rd_seen), 32'(0));
        chk("ow_mem_3_2", -1, 32'(mem[3][2]), 32'(50));
        chk("ow_mem_15_3", -1, 32'(mem[15][3]), 32'(243));
        chk("ow_mem_0_4", -1, 32'(mem[0][4]), 32'(16'hAAAA));

        // accumulate 100 + 5
        preload(16'd100);
        run_case(4, 1'b1, 1, 42, -1, -1);
        chk("acc_first_rd0", -1, 32'(first_rd0), 32'(17));
        chk("acc_first_wr0", -1, 32'(first_wr0), 32'(18));
        chk("acc_mem_7_1", -1, 32'(mem[7][1]), 32'(105));
        chk("acc_mem_15_3", -1, 32'(mem[15][3]), 32'(105));

        // wrap-around add
        preload(16'hFFFF);
        run_case(2, 1'b1, 2, 42, -1, -1);
        chk("wrap_mem_0_0", -1, 32'(mem[0][0]), 32'(1));
        chk("wrap_mem_9_1", -1, 32'(mem[9][1]), 32'(1));
        chk("wrap_done", -1, 32'(done_k), 32'(35));

        // zero rows
        run_case(0, 1'b1, 0, 6, -1, -1);
        chk("zero_done", -1, 32'(done_k), 32'(1));
        chk("zero_no_wr", -1, 32'(first_wr0), 32'(-1));
        chk("zero_no_rd", -1, 32'(rd_seen), 32'(0));

        // clamp 300 -> 256 rows
        preload('0);
        run_case(300, 1'b0, 0, 292, -1, -1);
        chk("clamp_done", -1, 32'(done_k), 32'(289));
        chk("clamp_max_addr", -1, 32'(max_wa), 32'(255));
        chk("clamp_mem_5_255", -1, 32'(mem[5][255]), 32'(335));

        // second start mid-run is ignored
        preload('0);
        run_case(4, 1'b0, 0, 42, 20, -1);
        chk("restart_done", -1, 32'(done_k), 32'(37));
        chk("restart_last_wr15", -1, 32'(last_wr15), 32'(36));

        // reset during RUN, then a clean run
        preload(16'd7);
        run_case(8, 1'b1, 1, 30, -1, 25);
        chk("rst_no_done", -1, 32'(done_k), 32'(-1));
        chk("rst_busy", -1, 32'(busy), 32'(0));
        preload('0);
        run_case(3, 1'b0, 0, 40, -1, -1);
        chk("post_rst_done", -1, 32'(done_k), 32'(36));
        chk("post_rst_mem_2_2", -1, 32'(mem[2][2]), 32'(34));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
